// File: rtl/src_wakeup_buffer_pkg.sv
// Shared constants for the operand wakeup buffer: default widths, slot layout
// and bus-slice helper widths.
package src_wakeup_buffer_pkg;

  localparam int DATA_LEN_DEF   = 32;
  localparam int RRF_SEL_DEF    = 6;
  localparam int NUM_BYPASS_DEF = 4;
  localparam int DEPTH_DEF      = 8;

  localparam int EXRSLT_W_DEF = NUM_BYPASS_DEF * DATA_LEN_DEF;
  localparam int EXDST_W_DEF  = NUM_BYPASS_DEF * RRF_SEL_DEF;

  // Slot layout; the tag, when unresolved, lives in value[RRF_SEL-1:0].
  typedef struct packed {
    logic                    valid;
    logic                    rdy;
    logic [DATA_LEN_DEF-1:0] value;
  } slot_t;

endpackage

// File: rtl/src_wakeup_buffer_bus_match.sv
// Matches one RRF tag against all result buses; lowest-index live hit wins.
module src_bus_match
  import src_wakeup_buffer_pkg::*;
#(
  parameter int DATA_LEN   = DATA_LEN_DEF,
  parameter int RRF_SEL    = RRF_SEL_DEF,
  parameter int NUM_BYPASS = NUM_BYPASS_DEF
) (
  input  logic [RRF_SEL-1:0]             tag,
  input  logic [NUM_BYPASS*DATA_LEN-1:0] exrslt,
  input  logic [NUM_BYPASS*RRF_SEL-1:0]  exdst,
  input  logic [NUM_BYPASS-1:0]          kill_spec,
  output logic                           hit,
  output logic [DATA_LEN-1:0]            data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    // Walk from the highest bus down so the lowest match is the last write.
    for (int k = NUM_BYPASS - 1; k >= 0; k--) begin
      if (!kill_spec[k] && (exdst[k*RRF_SEL +: RRF_SEL] == tag)) begin
        hit  = 1'b1;
        data = exrslt[k*DATA_LEN +: DATA_LEN];
      end
    end
  end

endmodule

// File: rtl/src_wakeup_buffer.sv
// Operand slot buffer for one reservation-station column with bus snooping.
// Optional macro SRC_WAKEUP_FWD_EN forwards same-cycle broadcasts on the read path.
module src_wakeup_buffer
  import src_wakeup_buffer_pkg::*;
#(
  parameter int DATA_LEN   = DATA_LEN_DEF,
  parameter int RRF_SEL    = RRF_SEL_DEF,
  parameter int NUM_BYPASS = NUM_BYPASS_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           alloc_vld,
  input  logic [IDX_W-1:0]               alloc_idx,
  input  logic [DATA_LEN-1:0]            alloc_opr,
  input  logic                           alloc_rdy,
  input  logic [NUM_BYPASS*DATA_LEN-1:0] exrslt,
  input  logic [NUM_BYPASS*RRF_SEL-1:0]  exdst,
  input  logic [NUM_BYPASS-1:0]          kill_spec,
  input  logic                           free_vld,
  input  logic [IDX_W-1:0]               free_idx,
  input  logic                           flush,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic                           rd_valid,
  output logic [DATA_LEN-1:0]            rd_src,
  output logic                           rd_resolved,
  output logic [IDX_W:0]                 pending_cnt
);

  logic [DEPTH-1:0]    valid_reg, valid_next;
  logic [DEPTH-1:0]    rdy_reg, rdy_next;
  logic [DATA_LEN-1:0] value_reg [DEPTH];
  logic [DATA_LEN-1:0] value_next [DEPTH];
  logic [IDX_W:0]      pending_next;

  logic                alloc_hit;
  logic [DATA_LEN-1:0] alloc_data;
  logic [DEPTH-1:0]    slot_hit;
  logic [DATA_LEN-1:0] slot_data [DEPTH];

  src_bus_match #(.DATA_LEN(DATA_LEN), .RRF_SEL(RRF_SEL), .NUM_BYPASS(NUM_BYPASS)) u_alloc_match (
    .tag(alloc_opr[RRF_SEL-1:0]), .exrslt(exrslt), .exdst(exdst), .kill_spec(kill_spec),
    .hit(alloc_hit), .data(alloc_data)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_match
    src_bus_match #(.DATA_LEN(DATA_LEN), .RRF_SEL(RRF_SEL), .NUM_BYPASS(NUM_BYPASS)) u_match (
      .tag(value_reg[gi][RRF_SEL-1:0]), .exrslt(exrslt), .exdst(exdst), .kill_spec(kill_spec),
      .hit(slot_hit[gi]), .data(slot_data[gi])
    );
  end

  always_comb begin
    valid_next   = valid_reg;
    rdy_next     = rdy_reg;
    value_next   = value_reg;
    pending_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        valid_next[i] = 1'b0;
        rdy_next[i]   = 1'b0;
        value_next[i] = '0;
      end else if (alloc_vld && alloc_idx == IDX_W'(i)) begin
        valid_next[i] = 1'b1;
        if (alloc_rdy || !alloc_hit) begin
          value_next[i] = alloc_opr;
          rdy_next[i]   = alloc_rdy;
        end else begin
          value_next[i] = alloc_data;
          rdy_next[i]   = 1'b1;
        end
      end else if (free_vld && free_idx == IDX_W'(i)) begin
        valid_next[i] = 1'b0;
        rdy_next[i]   = 1'b0;
      end else if (valid_reg[i] && !rdy_reg[i] && slot_hit[i]) begin
        value_next[i] = slot_data[i];
        rdy_next[i]   = 1'b1;
      end
      pending_next = pending_next + (IDX_W+1)'(valid_next[i] & ~rdy_next[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg   <= '0;
      rdy_reg     <= '0;
      pending_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) value_reg[i] <= '0;
    end else begin
      valid_reg   <= valid_next;
      rdy_reg     <= rdy_next;
      pending_cnt <= pending_next;
      for (int i = 0; i < DEPTH; i++) value_reg[i] <= value_next[i];
    end
  end

`ifdef SRC_WAKEUP_FWD_EN
  logic                fwd_hit;
  logic [DATA_LEN-1:0] fwd_data;
  logic [DATA_LEN-1:0] rd_value;

  assign rd_value = value_reg[rd_idx];

  src_bus_match #(.DATA_LEN(DATA_LEN), .RRF_SEL(RRF_SEL), .NUM_BYPASS(NUM_BYPASS)) u_fwd_match (
    .tag(rd_value[RRF_SEL-1:0]), .exrslt(exrslt), .exdst(exdst), .kill_spec(kill_spec),
    .hit(fwd_hit), .data(fwd_data)
  );

  always_comb begin
    rd_valid    = valid_reg[rd_idx];
    rd_resolved = valid_reg[rd_idx] & rdy_reg[rd_idx];
    rd_src      = valid_reg[rd_idx] ? rd_value : '0;
    if (valid_reg[rd_idx] && !rdy_reg[rd_idx] && fwd_hit) begin
      rd_resolved = 1'b1;
      rd_src      = fwd_data;
    end
  end
`else
  always_comb begin
    rd_valid    = valid_reg[rd_idx];
    rd_resolved = valid_reg[rd_idx] & rdy_reg[rd_idx];
    rd_src      = valid_reg[rd_idx] ? value_reg[rd_idx] : '0;
  end
`endif

endmodule

// File: doc/src_wakeup_buffer.md
Name: src_wakeup_buffer

Overview:
- Parametrised, stateful successor to the per-operand source resolver; one instance serves one reservation-station operand column.
- Holds DEPTH operand slots; each slot holds either a ready value or an RRF tag.
- Every cycle, snoops NUM_BYPASS execution-result buses. A matching broadcast captures its result into the slot and marks the slot resolved.
- Issue logic reads any slot by index.

Parameters:
- DATA_LEN, 32, operand/result width
- RRF_SEL, 6, RRF tag width (tag held in low RRF_SEL bits of the slot value)
- NUM_BYPASS, 4, number of result broadcast buses
- DEPTH, 8, number of slots (power of two, >=2)
- IDX_W, $clog2(DEPTH), slot index width (derived)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- alloc_vld  in  1  write slot alloc_idx this cycle
- alloc_idx  in  IDX_W  target slot
- alloc_opr  in  DATA_LEN  value if alloc_rdy, else tag (zero-extended)
- alloc_rdy  in  1  alloc_opr is a value
- exrslt  in  NUM_BYPASS*DATA_LEN  packed results; bus k at [k*DATA_LEN +: DATA_LEN]
- exdst  in  NUM_BYPASS*RRF_SEL  packed destination tags
- kill_spec  in  NUM_BYPASS  bus k invalid this cycle
- free_vld  in  1  invalidate slot free_idx
- free_idx  in  IDX_W  slot to free
- flush  in  1  invalidate all slots
- rd_idx  in  IDX_W  combinational read index
- rd_valid  out  1  slot rd_idx valid
- rd_src  out  DATA_LEN  slot value or tag
- rd_resolved  out  1  slot holds a value
- pending_cnt  out  IDX_W+1  registered count of valid, unresolved slots

Behaviour:
- Reset (async, reset_n=0):
  - All slot valid/rdy/value cleared.
  - pending_cnt=0.
  - rd_valid, rd_resolved and rd_src read 0.
- Bus match for bus k: ~kill_spec[k] & (exdst[k] == tag), where tag is slot value[RRF_SEL-1:0]. Upper value bits are ignored.
- Multiple matches on one slot in one cycle: the lowest k wins. This is the same priority order as the original resolver.
- Allocation (registered, visible next cycle):
  - The slot is written valid=1.
  - If alloc_rdy: value=alloc_opr, rdy=1.
  - Otherwise the slot resolves against the same-cycle buses using alloc_opr as the tag.
    - On a match: value=exrslt of the winning bus, rdy=1.
    - With no match: value=alloc_opr, rdy=0.
- Wakeup: each valid, unready slot not being allocated this cycle that matches a bus captures value=exrslt and sets rdy=1 at the next edge. It stays captured; later broadcasts are ignored.
- Free: clears valid and rdy at the next edge.
- Priority when events collide:
  - Reset over flush.
  - Flush over alloc.
  - Alloc over free to the same slot.
  - Alloc over wakeup.
- Alloc to an already-valid slot overwrites it silently.
- Free of an invalid slot is a no-op.
- Read path: combinational from registered slot state. Invalid slots read rd_src=0 and rd_resolved=0.
- pending_cnt: popcount of valid & ~rdy, computed on next-state values so it matches slot state in the same cycle.
- Bus arrival to rd_resolved latency: 1 cycle (0 cycles with the optional feature).

Optional Feature:
- SRC_WAKEUP_FWD_EN defined:
  - Read path also checks the current-cycle buses.
  - If the slot is valid, unready and matches a bus, rd_resolved=1 and rd_src=exrslt of the winning bus in the same cycle.
  - Registered state still updates at the edge.
- SRC_WAKEUP_FWD_EN undefined: read path is purely registered.

Decomposition:
- Shared package (constants include):
  - DATA_LEN and RRF_SEL defaults.
  - Slot struct/field layout {valid, rdy, value}.
  - Bus-slice helper widths.
- Sub-module src_bus_match: combinational match of one tag against all buses. Outputs hit and the lowest-index hit data.
  - Instantiated once for alloc, DEPTH times for slot wakeup, and once more for forwarding when enabled.

Test Plan:
- Reset/ready alloc: reset, then alloc idx2 value 0x1234 rdy=1 → next cycle rd_idx=2 gives rd_valid=1, rd_resolved=1, rd_src=0x1234, pending_cnt=0.
- Deferred wakeup:
  - Alloc idx0 tag 5 rdy=0 → pending_cnt=1, rd_resolved=0, rd_src=5.
  - Two cycles later bus2 exdst=5 exrslt=0xBEEF → next cycle rd_resolved=1, rd_src=0xBEEF, pending_cnt=0.
  - Without the macro, rd_resolved=0 during the broadcast cycle; with the macro, rd_resolved=1 in that same cycle.
- Same-cycle alloc bypass with priority: alloc tag 9 while bus0 kill_spec=1 exdst=9 and bus1 exdst=9 exrslt=0xA, bus3 exdst=9 exrslt=0xB → slot value 0xA, rdy=1.
- Collisions:
  - Alloc and free of idx4 in the same cycle → slot valid.
  - Flush with alloc idx1 → all slots invalid, pending_cnt=0.
- Full occupancy: fill all 8 slots unready with tags 0..7, then broadcast tags 3 and 6 on buses 0/1 → pending_cnt 8→6; slots 3 and 6 resolved.
- Reset mid-operation: assert reset_n=0 asynchronously between edges with slots pending → outputs zero immediately; no wakeup captured after release.
